// File: rtl/msj_pid_engine_mux.sv
// rtl/msj_pid_engine_mux.sv - time-multiplexed PID engine with Avalon-MM register file
module msj_pid_engine_mux #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int DATA_WIDTH       = 32,
    parameter int WATCHDOG_CYCLES  = 50_000_000
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [15:0]                            address,
    input  logic                                   write,
    input  logic [31:0]                            writedata,
    input  logic                                   read,
    output logic [31:0]                            readdata,
    output logic                                   waitrequest,
    input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] position,
    input  logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] velocity,
    input  logic [NUMBER_OF_MOTORS-1:0]            update_strobe,
    input  logic                                   emergency_off,
    output logic [NUMBER_OF_MOTORS*DATA_WIDTH-1:0] duty,
    output logic [NUMBER_OF_MOTORS-1:0]            duty_valid,
    output logic                                   watchdog_tripped
);
    localparam int N   = NUMBER_OF_MOTORS;
    localparam int DW  = DATA_WIDTH;
    localparam int W   = 2 * DW + 2;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam logic [7:0]     N8       = 8'(N);
    localparam logic [CW-1:0]  LAST_CH  = CW'(N - 1);
    localparam logic [CW:0]    N_WIDE   = (CW + 1)'(N);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(WATCHDOG_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ERR, S_MUL, S_SUM, S_SAT, S_WB} state_t;
    state_t state, state_nx;

    logic signed [DW-1:0] kp [N], ki [N], kd [N], sp [N];
    logic signed [DW-1:0] pos_max [N], neg_max [N], dead_band [N], integ_max [N];
    logic signed [DW-1:0] integ [N], duty_q [N], pos_a [N], vel_a [N];
    logic signed [DW:0]   prev_e [N];
    logic [1:0]           mode [N];
    logic [4:0]           out_shift [N];
    logic [N-1:0]         pending, pend_eff, fetch_clr;
    logic [CW-1:0]        ptr, cur_ch, sel_ch, a_ch;
    logic [CW:0]          rr_idx;
    logic                 sel_found, take, stop, ch_ok, sp_wr, rd_ack;
    logic [WDW-1:0]       wd_cnt;
    logic [31:0]          rd_val;

    logic [1:0]           mode_l;
    logic [4:0]           shift_l;
    logic signed [DW-1:0] kp_l, ki_l, kd_l, sp_l, fb_l, pmax_l, nmax_l, db_l, imax_l, integ_l;
    logic signed [DW-1:0] integ_nx_q, res_q, sat_val;
    logic signed [DW:0]   preve_l, err_q, err_raw;
    logic [DW:0]          err_mag;
    logic                 in_band;
    logic signed [DW+1:0] isum, ilim, isat, derr;
    logic signed [W-1:0]  p_kp, p_ki, p_kd;
    logic signed [W+1:0]  acc_q, acc_nx, sat_in;

    for (genvar j = 0; j < N; j++) begin : g_ch
        assign pos_a[j] = position[j*DW +: DW];
        assign vel_a[j] = velocity[j*DW +: DW];
        assign duty[j*DW +: DW] = duty_q[j];
    end

    assign stop        = emergency_off | watchdog_tripped;
    assign a_ch        = CW'(address[7:0]);
    assign ch_ok       = address[7:0] < N8;
    assign sp_wr       = write && ch_ok && (address[15:8] == 8'h03);
    assign waitrequest = reset | (read & ~rd_ack);
    assign take        = ((state == S_IDLE) || (state == S_WB)) && sel_found;
    assign fetch_clr   = (state == S_FETCH) ? (N'(1) << cur_ch) : '0;

    // Round-robin: first pending channel at or after ptr; fresh strobes count so IDLE reacts at once
    always_comb begin
        pend_eff  = pending | update_strobe;
        sel_found = 1'b0;
        sel_ch    = '0;
        rr_idx    = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = {1'b0, ptr} + (CW + 1)'(k);
            if (rr_idx >= N_WIDE) rr_idx = rr_idx - N_WIDE;
            if (!sel_found && pend_eff[rr_idx[CW-1:0]]) begin
                sel_found = 1'b1;
                sel_ch    = rr_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (sel_found) state_nx = S_FETCH;
            S_FETCH: state_nx = S_ERR;
            S_ERR:   state_nx = S_MUL;
            S_MUL:   state_nx = S_SUM;
            S_SUM:   state_nx = S_SAT;
            S_SAT:   state_nx = S_WB;
            S_WB:    state_nx = sel_found ? S_FETCH : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        err_raw = (DW + 1)'(sp_l) - (DW + 1)'(fb_l);
        err_mag = err_raw[DW] ? -err_raw : err_raw;
        in_band = !db_l[DW-1] && ({1'b0, err_mag} <= {2'b00, db_l});
        isum    = (DW + 2)'(integ_l) + (DW + 2)'(err_q);
        ilim    = (DW + 2)'(imax_l);
        if (isum > ilim)       isat = ilim;
        else if (isum < -ilim) isat = -ilim;
        else                   isat = isum;
        derr    = (DW + 2)'(err_q) - (DW + 2)'(preve_l);
        acc_nx  = ((W + 2)'(p_kp) + (W + 2)'(p_ki) + (W + 2)'(p_kd)) >>> shift_l;
        sat_in  = (mode_l == 2'd2) ? (W + 2)'(sp_l) : acc_q;
        if (mode_l == 2'd3)                  sat_val = '0;
        else if (sat_in > (W + 2)'(pmax_l))  sat_val = pmax_l;
        else if (sat_in < (W + 2)'(nmax_l))  sat_val = nmax_l;
        else                                 sat_val = sat_in[DW-1:0];
    end

    always_comb begin
        rd_val = 32'hDEAD_BEEF;
        if (ch_ok) begin
            case (address[15:8])
                8'h00: rd_val = 32'(kp[a_ch]);
                8'h01: rd_val = 32'(ki[a_ch]);
                8'h02: rd_val = 32'(kd[a_ch]);
                8'h03: rd_val = 32'(sp[a_ch]);
                8'h04: rd_val = {30'b0, mode[a_ch]};
                8'h05: rd_val = {27'b0, out_shift[a_ch]};
                8'h06: rd_val = 32'(pos_max[a_ch]);
                8'h07: rd_val = 32'(neg_max[a_ch]);
                8'h08: rd_val = 32'(dead_band[a_ch]);
                8'h09: rd_val = 32'(integ_max[a_ch]);
                8'h10: rd_val = 32'(duty_q[a_ch]);
                8'h11: rd_val = 32'(integ[a_ch]);
                8'h12: rd_val = {29'b0, pending[a_ch], emergency_off, watchdog_tripped};
                default: rd_val = 32'hDEAD_BEEF;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < N; j++) begin
                kp[j] <= '0; ki[j] <= '0; kd[j] <= '0; sp[j] <= '0;
                pos_max[j] <= DW'(10000); neg_max[j] <= DW'(-10000);
                dead_band[j] <= '0; integ_max[j] <= '0;
                integ[j] <= '0; duty_q[j] <= '0; prev_e[j] <= '0;
                mode[j] <= 2'd3; out_shift[j] <= 5'd7;
            end
            pending <= '0; ptr <= '0; cur_ch <= '0;
            duty_valid <= '0; watchdog_tripped <= 1'b0; wd_cnt <= '0;
            readdata <= '0; rd_ack <= 1'b0;
            mode_l <= 2'd3; shift_l <= '0;
            kp_l <= '0; ki_l <= '0; kd_l <= '0; sp_l <= '0; fb_l <= '0;
            pmax_l <= '0; nmax_l <= '0; db_l <= '0; imax_l <= '0; integ_l <= '0;
            preve_l <= '0; err_q <= '0; integ_nx_q <= '0; res_q <= '0;
            p_kp <= '0; p_ki <= '0; p_kd <= '0; acc_q <= '0;
        end else begin
            duty_valid <= '0;
            pending    <= (pending & ~fetch_clr) | update_strobe;
            if (take) begin
                cur_ch <= sel_ch;
                ptr    <= (sel_ch == LAST_CH) ? '0 : sel_ch + 1'b1;
            end
            case (state)
                S_FETCH: begin
                    mode_l <= mode[cur_ch]; shift_l <= out_shift[cur_ch];
                    kp_l <= kp[cur_ch]; ki_l <= ki[cur_ch]; kd_l <= kd[cur_ch]; sp_l <= sp[cur_ch];
                    fb_l <= (mode[cur_ch] == 2'd1) ? vel_a[cur_ch] : pos_a[cur_ch];
                    pmax_l <= pos_max[cur_ch]; nmax_l <= neg_max[cur_ch];
                    db_l <= dead_band[cur_ch]; imax_l <= integ_max[cur_ch];
                    integ_l <= integ[cur_ch]; preve_l <= prev_e[cur_ch];
                end
                S_ERR: err_q <= in_band ? '0 : err_raw;
                S_MUL: begin
                    p_kp       <= W'(kp_l) * W'(err_q);
                    p_ki       <= W'(ki_l) * W'(isat);
                    p_kd       <= W'(kd_l) * W'(derr);
                    integ_nx_q <= isat[DW-1:0];
                end
                S_SUM: acc_q <= acc_nx;
                S_SAT: res_q <= sat_val;
                S_WB: begin
                    duty_valid[cur_ch] <= 1'b1;
                    duty_q[cur_ch]     <= stop ? '0 : res_q;
                    case (mode_l)
                        2'd2: ;
                        2'd3: begin integ[cur_ch] <= '0; prev_e[cur_ch] <= '0; end
                        default: begin integ[cur_ch] <= integ_nx_q; prev_e[cur_ch] <= err_q; end
                    endcase
                end
                default: ;
            endcase
            if (stop) begin
                for (int j = 0; j < N; j++) begin
                    duty_q[j] <= '0;
                    integ[j]  <= '0;
                end
            end
            // Host writes come last so a clear-integral strobe beats a same-cycle writeback
            if (write && ch_ok) begin
                case (address[15:8])
                    8'h00: kp[a_ch]        <= writedata[DW-1:0];
                    8'h01: ki[a_ch]        <= writedata[DW-1:0];
                    8'h02: kd[a_ch]        <= writedata[DW-1:0];
                    8'h03: sp[a_ch]        <= writedata[DW-1:0];
                    8'h04: mode[a_ch]      <= writedata[1:0];
                    8'h05: out_shift[a_ch] <= writedata[4:0];
                    8'h06: pos_max[a_ch]   <= writedata[DW-1:0];
                    8'h07: neg_max[a_ch]   <= writedata[DW-1:0];
                    8'h08: dead_band[a_ch] <= writedata[DW-1:0];
                    8'h09: integ_max[a_ch] <= writedata[DW-1:0];
                    8'h0A: integ[a_ch]     <= '0;
                    default: ;
                endcase
            end
            rd_ack <= read && !rd_ack;
            if (read && !rd_ack) readdata <= rd_val;
            if (sp_wr) begin
                wd_cnt           <= '0;
                watchdog_tripped <= 1'b0;
            end else if ((WATCHDOG_CYCLES != 0) && (wd_cnt != WD_LIMIT)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt + 1'b1 == WD_LIMIT) watchdog_tripped <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_msj_pid_engine_mux.sv
// tb/tb_msj_pid_engine_mux.sv - directed-vector bench for msj_pid_engine_mux
module tb_msj_pid_engine_mux;
    localparam int N  = 6;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   address;
    logic          write;
    logic [31:0]   writedata;
    logic          read;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [N*DW-1:0] position;
    logic [N*DW-1:0] velocity;
    logic [N-1:0]  update_strobe;
    logic          emergency_off;
    logic [N*DW-1:0] duty;
    logic [N-1:0]  duty_valid;
    logic          watchdog_tripped;

    int checks = 0;
    int errors = 0;

    msj_pid_engine_mux #(
        .NUMBER_OF_MOTORS(N),
        .DATA_WIDTH(DW),
        .WATCHDOG_CYCLES(1000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .write(write),
        .writedata(writedata),
        .read(read),
        .readdata(readdata),
        .waitrequest(waitrequest),
        .position(position),
        .velocity(velocity),
        .update_strobe(update_strobe),
        .emergency_off(emergency_off),
        .duty(duty),
        .duty_valid(duty_valid),
        .watchdog_tripped(watchdog_tripped)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] duty_of(input int ch);
        return duty[ch*DW +: DW];
    endfunction

    task automatic reg_write(input logic [7:0] r, input logic [7:0] ch, input logic [31:0] d);
        address = {r, ch}; writedata = d; write = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [7:0] r, input logic [7:0] ch,
                            input logic [31:0] exp);
        address = {r, ch}; read = 1'b1;
        #2;
        check({tag, "_wait_hi"}, 32'(waitrequest), 32'd1);
        @(posedge clock); #1;
        check({tag, "_wait_lo"}, 32'(waitrequest), 32'd0);
        check(tag, readdata, exp);
        @(posedge clock); #1;
        read = 1'b0;
    endtask

    task automatic wait_valid(input int ch, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (duty_valid[ch[2:0]]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_check(input string tag, input int ch, input logic [31:0] exp);
        int lat;
        update_strobe = N'(1) << ch;
        @(posedge clock); #1;
        update_strobe = '0;
        wait_valid(ch, lat);
        check({tag, "_lat"}, 32'(lat), 32'd6);
        check(tag, duty_of(ch), exp);
    endtask

    task automatic run_window(input string tag, input logic [N-1:0] m0, input logic [N-1:0] m1,
                              input logic [N-1:0] m2, output int first [N], output int cnt [N]);
        for (int c = 0; c < N; c++) begin first[c] = -1; cnt[c] = 0; end
        update_strobe = m0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            for (int c = 0; c < N; c++) begin
                if (duty_valid[c]) begin
                    cnt[c]++;
                    if (first[c] < 0) first[c] = i;
                end
            end
            update_strobe = (i == 0) ? m1 : (i == 1) ? m2 : '0;
        end
    endtask

    initial begin
        int first [N];
        int cnt [N];
        int lat;
        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        position = '0; velocity = '0; update_strobe = '0; emergency_off = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_wait", 32'(waitrequest), 32'd1);
        check("rst_duty", 32'(duty != '0), 32'd0);
        check("rst_valid", 32'(duty_valid), 32'd0);
        check("rst_wd", 32'(watchdog_tripped), 32'd0);
        check("rst_rdata", readdata, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Proportional: e=100, 4*100>>2 = 100
        position[0*DW +: DW] = 900;
        reg_write(8'h00, 8'd0, 4);
        reg_write(8'h05, 8'd0, 2);
        reg_write(8'h03, 8'd0, 1000);
        reg_write(8'h04, 8'd0, 0);
        pulse_check("prop", 0, 32'd100);
        @(posedge clock); #1;
        check("valid_one_cycle", 32'(duty_valid), 32'd0);

        reg_write(8'h00, 8'd0, 1000);
        pulse_check("sat_pos", 0, 32'd10000);
        reg_write(8'h08, 8'd0, 150);
        pulse_check("deadband", 0, 32'd0);

        // Integral clamp: 100, 200, then 300 clamped to 250
        reg_write(8'h08, 8'd0, 0);
        reg_write(8'h00, 8'd0, 0);
        reg_write(8'h01, 8'd0, 1);
        reg_write(8'h05, 8'd0, 0);
        reg_write(8'h09, 8'd0, 250);
        pulse_check("integ1", 0, 32'd100);
        pulse_check("integ2", 0, 32'd200);
        pulse_check("integ3", 0, 32'd250);
        reg_read("rd_integ", 8'h11, 8'd0, 32'd250);

        reg_read("rd_posmax", 8'h06, 8'd0, 32'd10000);
        reg_read("rd_negmax", 8'h07, 8'd0, 32'hFFFF_D8F0);
        reg_read("rd_badch", 8'h00, 8'hFF, 32'hDEAD_BEEF);
        reg_read("rd_badreg", 8'h20, 8'd0, 32'hDEAD_BEEF);
        reg_write(8'h00, 8'd6, 77);
        reg_read("wr_ign_ch0", 8'h00, 8'd0, 32'd0);
        reg_read("wr_ign_ch5", 8'h00, 8'd5, 32'd0);

        // Round-robin on ch0/3/5 (ch5 served first so the pointer wraps to 0)
        reg_write(8'h04, 8'd3, 0); reg_write(8'h05, 8'd3, 0);
        reg_write(8'h00, 8'd3, 1); reg_write(8'h03, 8'd3, 30);
        reg_write(8'h04, 8'd5, 0); reg_write(8'h05, 8'd5, 0);
        reg_write(8'h00, 8'd5, 1); reg_write(8'h03, 8'd5, 50);
        pulse_check("ch5_single", 5, 32'd50);
        run_window("rr", 6'b101001, 6'b0, 6'b0, first, cnt);
        check("rr_t0", 32'(first[0]), 32'd6);
        check("rr_t3", 32'(first[3]), 32'd12);
        check("rr_t5", 32'(first[5]), 32'd18);
        check("rr_cnt0", 32'(cnt[0]), 32'd1);
        check("rr_duty0", duty_of(0), 32'd250);
        check("rr_duty3", duty_of(3), 32'd30);

        run_window("merge", 6'b001000, 6'b000001, 6'b000001, first, cnt);
        check("merge_t3", 32'(first[3]), 32'd6);
        check("merge_t0", 32'(first[0]), 32'd12);
        check("merge_cnt0", 32'(cnt[0]), 32'd1);

        // Emergency stop mid-computation
        update_strobe = 6'b001000;
        @(posedge clock); #1;
        update_strobe = '0;
        @(posedge clock); #1;
        emergency_off = 1'b1;
        @(posedge clock); #1;
        check("estop_duty3", duty_of(3), 32'd0);
        check("estop_duty0", duty_of(0), 32'd0);
        wait_valid(3, lat);
        check("estop_lat", 32'(lat), 32'd4);
        check("estop_wb", duty_of(3), 32'd0);
        reg_read("estop_status", 8'h12, 8'd0, 32'd2);
        reg_read("estop_integ", 8'h11, 8'd0, 32'd0);
        emergency_off = 1'b0;
        pulse_check("estop_resume", 3, 32'd30);

        reg_write(8'h04, 8'd5, 2);
        reg_write(8'h03, 8'd5, 20000);
        pulse_check("direct", 5, 32'd10000);
        reg_write(8'h04, 8'd5, 3);
        pulse_check("disabled", 5, 32'd0);

        // Watchdog trips 1000 cycles after the last set-point write
        reg_write(8'h03, 8'd5, 0);
        repeat (990) @(posedge clock);
        #1;
        check("wd_early", 32'(watchdog_tripped), 32'd0);
        repeat (20) @(posedge clock);
        #1;
        check("wd_trip", 32'(watchdog_tripped), 32'd1);
        check("wd_duty3", duty_of(3), 32'd0);
        reg_read("wd_status", 8'h12, 8'd0, 32'd1);
        reg_write(8'h03, 8'd3, 30);
        check("wd_clear", 32'(watchdog_tripped), 32'd0);
        pulse_check("wd_resume", 3, 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
